uart_rx: RTL and testbench
==========================

// Module: uart_rx
// PURPOSE
//  16x-oversampled UART receiver; the downstream partner of UART_TX.
//  Recovers frames from the serial line and presents each byte with a 1-cycle valid strobe and error flags.
//  Frame format is set by the same BITS/STOPBITS/PARITY parameters as UART_TX, so a TX/RX pair agrees by construction.
//  clk is the 16x baud tick clock: one bit period = BITLEN = 16 clk cycles.
// PARAMETERS
//  BITS      8  data bits per frame, LSB first.
//  STOPBITS  1  stop bits checked, 1 or 2.
//  PARITY    0  0 = none; 1 = odd (bit = ~^data); 2 = even (bit = ^data).
// PORTS
//  clk           in   1     16x baud clock.
//  rst           in   1     asynchronous, active-low reset.
//  rx            in   1     serial line; idles high (external pull-up; TX tri-states when idle).
//  data          out  BITS  last received word; held until the next data_valid.
//  data_valid    out  1     1-cycle strobe: data/parity_error/frame_error updated this cycle.
//  parity_error  out  1     received parity mismatched; always 0 when PARITY==0.
//  frame_error   out  1     a sampled stop bit was 0.
//  busy          out  1     high from start-edge detect until return to IDLE.
// BEHAVIOUR
//  Reset (async, rst==0):
//   - state=IDLE; synchroniser flops=1; data=0.
//   - data_valid, parity_error, frame_error and busy all =0.
//  Synchroniser: rx passes through 2 flops -> rx_s. All decisions use rx_s (2-cycle input latency).
//  States (one-hot): IDLE, START, DATA, PARITY, STOP.
//  IDLE:
//   - Armed only once rx_s==1 has been seen.
//   - When armed and rx_s==0: go to START, counter=0, busy=1.
//  START: counter increments each cycle; at counter==BITLEN/2-1 (7) sample mid-bit.
//   - rx_s==1: glitch. Return to IDLE with no strobe and no flags.
//   - rx_s==0: counter=0, bit_idx=0, go to DATA.
//  DATA: sample at counter==BITLEN-1, i.e. every 16 cycles at mid-bit.
//   - Shift the sample into shreg[BITS-1], shifting right.
//   - After BITS samples, go to PARITY if PARITY!=0, else STOP.
//  PARITY:
//   - Sample at counter==BITLEN-1.
//   - perr = sample != expected bit per the PARITY code.
//  STOP:
//   - Sample each stop bit at counter==BITLEN-1.
//   - ferr |= (sample==0).
//   - After STOPBITS samples, on the next cycle:
//     data=shreg, parity_error=perr, frame_error=ferr, data_valid=1, busy=0, state=IDLE.
//  Latency: data_valid rises 1 cycle after the final stop-bit mid-sample.
//   - 8N1: 8+16*9+1 = 153 clk after start-edge detect.
//  Flags persist until the next data_valid; they are never cleared by idle time.
//  Line held low after a frame_error (break): IDLE stays disarmed until rx_s==1.
//   - No spurious frames are produced.
//  No overrun detection: the consumer must take data before the next data_valid (>=1 frame later).
//  Reset asserted mid-frame: immediate abort. No strobe. Receiver re-arms only on rx_s==1 after reset.
//  Counter width: $clog2(BITLEN). bit_idx width: $clog2(BITS+1).
// STRUCTURE
//  Shared header uart_defs.vh:
//   - BITLEN=16.
//   - Parity codes PARITY_NONE=0, PARITY_ODD=1, PARITY_EVEN=2.
//   - State encodings.
//   - UART_TX includes the same header.
//  Sub-module uart_sync: 2-flop synchroniser.
//   - Parameterised reset value (1 here).
//   - Async active-low reset.
//  All other logic stays in uart_rx.
// TESTING (all frames driven by a UART_TX instance with matching parameters, looped back, unless noted)
//  1. 8N1, send 0xA5:
//     data_valid pulses once 153 clk after the edge is seen; data=0xA5; parity_error=0; frame_error=0.
//  2. PARITY=1, send 0x07 (odd parity bit=0):
//     clean frame -> parity_error=0.
//     Bench flips the parity bit, then sends 0x07 -> data=0x07, parity_error=1.
//  3. Glitch: drive rx low for 5 clk, then high.
//     No data_valid; busy returns to 0 within 8 clk of the glitch being seen.
//  4. Framing: bench-driven frame 0x3C with stop bit=0, then rx held low 400 clk, then high.
//     One data_valid, frame_error=1, data=0x3C, no further strobes.
//     After rx goes high, next frame 0x81 -> frame_error=0.
//  5. Reset mid-frame: assert rst at DATA bit 4 of 0xFF.
//     All outputs return to reset values at once and no strobe appears.
//     Next clean 0x12 is received correctly.
//  6. STOPBITS=2: back-to-back 0x00, 0xFF, 0x55.
//     Three strobes, correct data, no flags.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared definitions for the 16x-oversampled UART receiver.
//   BITLEN       : clk cycles per bit period (clk is the 16x baud tick).
//   PARITY_*     : parity mode codes; UART_TX uses the same values.
//   rx_state_e   : one-hot receiver states.
//   parity_bit() : parity bit a transmitter sends, given the XOR of the data.
package uart_rx_pkg;

    localparam int BITLEN      = 16;
    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    typedef enum logic [4:0] {
        ST_IDLE   = 5'b00001,
        ST_START  = 5'b00010,
        ST_DATA   = 5'b00100,
        ST_PARITY = 5'b01000,
        ST_STOP   = 5'b10000
    } rx_state_e;

    // Odd parity makes the total number of ones odd, so the bit is the
    // inverse of the data XOR; even parity sends the XOR itself.
    function automatic logic parity_bit(input logic xor_all, input int code);
        return (code == PARITY_ODD) ? ~xor_all : xor_all;
    endfunction

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchroniser for an asynchronous single-bit input.
//   clk : sampling clock
//   rst : asynchronous active-low reset; both flops load RESET_VAL
//   d   : asynchronous input
//   q   : synchronised output, two cycles behind d
module uart_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 16x-oversampled UART receiver, LSB first, optional parity, 1 or 2 stop bits.
//   clk          : 16x baud clock
//   rst          : asynchronous active-low reset
//   rx           : serial line, idles high
//   data         : last received word, held until the next data_valid
//   data_valid   : 1-cycle strobe; data and both error flags update with it
//   parity_error : parity mismatch of the last frame (0 when PARITY==0)
//   frame_error  : a stop bit of the last frame was sampled low
//   busy         : high from start-edge detection until back in IDLE
//
// Handshake: data_valid is a single-cycle strobe with no ready/back-pressure;
// the consumer must take data/flags before the next strobe (at least one frame
// later). The outputs hold their values between strobes.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int BITS     = 8,
    parameter int STOPBITS = 1,
    parameter int PARITY   = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rx,
    output logic [BITS-1:0] data,
    output logic            data_valid,
    output logic            parity_error,
    output logic            frame_error,
    output logic            busy
);

    localparam int CW = $clog2(BITLEN);
    localparam int IW = $clog2(BITS + 1);
    localparam logic [CW-1:0] CNT_HALF  = CW'(BITLEN / 2 - 1);
    localparam logic [CW-1:0] CNT_FULL  = CW'(BITLEN - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(BITS - 1);
    localparam logic [IW-1:0] IDX_STOPS = IW'(STOPBITS);

    rx_state_e       state_q, state_d;
    logic            rx_s;
    logic [CW-1:0]   cnt;
    logic [IW-1:0]   bit_idx;
    logic [BITS-1:0] shreg;
    logic            perr, ferr;
    logic            armed;
    logic            mid;
    logic            stop_done;

    uart_sync #(.RESET_VAL(1'b1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (rx_s)
    );

    // Once START has re-aligned the counter to mid-bit, every later sample
    // falls exactly one bit period on, when the counter wraps.
    assign mid       = (cnt == CNT_FULL);
    // In STOP, bit_idx counts stop samples taken; reaching STOPBITS means the
    // frame is complete and this cycle publishes it.
    assign stop_done = (bit_idx == IDX_STOPS);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (armed && !rx_s) state_d = ST_START;
            ST_START:  if (cnt == CNT_HALF) state_d = rx_s ? ST_IDLE : ST_DATA;
            ST_DATA:   if (mid && bit_idx == IDX_LAST)
                           state_d = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
            ST_PARITY: if (mid) state_d = ST_STOP;
            ST_STOP:   if (stop_done) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt          <= '0;
            bit_idx      <= '0;
            shreg        <= '0;
            perr         <= 1'b0;
            ferr         <= 1'b0;
            armed        <= 1'b0;
            data         <= '0;
            data_valid   <= 1'b0;
            parity_error <= 1'b0;
            frame_error  <= 1'b0;
            busy         <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            busy       <= (state_d != ST_IDLE);
            // Disarmed on every return to IDLE so a line held low after a
            // frame (break) cannot be mistaken for a new start bit.
            armed      <= (state_q == ST_IDLE) ? (armed | rx_s) : 1'b0;
            case (state_q)
                ST_IDLE: begin
                    cnt     <= '0;
                    bit_idx <= '0;
                    perr    <= 1'b0;
                    ferr    <= 1'b0;
                end
                ST_START: begin
                    cnt <= (cnt == CNT_HALF) ? '0 : cnt + 1'b1;
                end
                ST_DATA: begin
                    cnt <= cnt + 1'b1;
                    if (mid) begin
                        shreg   <= {rx_s, shreg[BITS-1:1]};
                        bit_idx <= (bit_idx == IDX_LAST) ? '0 : bit_idx + 1'b1;
                    end
                end
                ST_PARITY: begin
                    cnt <= cnt + 1'b1;
                    if (mid) perr <= (rx_s != parity_bit(^shreg, PARITY));
                end
                ST_STOP: begin
                    cnt <= cnt + 1'b1;
                    if (mid && !stop_done) begin
                        ferr    <= ferr | ~rx_s;
                        bit_idx <= bit_idx + 1'b1;
                    end
                    if (stop_done) begin
                        data         <= shreg;
                        parity_error <= perr;
                        frame_error  <= ferr;
                        data_valid   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Testbench for uart_rx: three receivers (8N1, 8O1, 8N2) each with its own
// serial line, driven by a behavioural transmitter task. Received words are
// captured by negedge monitors and compared against a frame-level model.
module tb_uart_rx;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUTs ----------------
    logic       rx_a, rx_b, rx_c;
    logic [7:0] data_a, data_b, data_c;
    logic       dv_a, dv_b, dv_c;
    logic       pe_a, pe_b, pe_c;
    logic       fe_a, fe_b, fe_c;
    logic       busy_a, busy_b, busy_c;

    uart_rx #(.BITS(8), .STOPBITS(1), .PARITY(0)) u_8n1 (
        .clk(clk), .rst(rst), .rx(rx_a), .data(data_a), .data_valid(dv_a),
        .parity_error(pe_a), .frame_error(fe_a), .busy(busy_a));

    uart_rx #(.BITS(8), .STOPBITS(1), .PARITY(1)) u_8o1 (
        .clk(clk), .rst(rst), .rx(rx_b), .data(data_b), .data_valid(dv_b),
        .parity_error(pe_b), .frame_error(fe_b), .busy(busy_b));

    uart_rx #(.BITS(8), .STOPBITS(2), .PARITY(0)) u_8n2 (
        .clk(clk), .rst(rst), .rx(rx_c), .data(data_c), .data_valid(dv_c),
        .parity_error(pe_c), .frame_error(fe_c), .busy(busy_c));

    // ---------------- monitors / scoreboard ----------------
    // Words are {data[7:0], parity_error, frame_error}.
    logic [9:0] obs_a[$], obs_b[$], obs_c[$];
    int         t_a[$];
    logic [9:0] exp_q[$];
    int         busy_rise_a = -1;
    logic       busy_a_prev = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    always @(negedge clk) begin
        if (dv_a === 1'b1) begin
            obs_a.push_back({data_a, pe_a, fe_a});
            t_a.push_back(cyc);
        end
        if (dv_b === 1'b1) obs_b.push_back({data_b, pe_b, fe_b});
        if (dv_c === 1'b1) obs_c.push_back({data_c, pe_c, fe_c});
        if (busy_a === 1'b1 && busy_a_prev !== 1'b1) busy_rise_a = cyc;
        busy_a_prev = busy_a;
    end

    // Frame-level reference: what a receiver must report for a given frame.
    function automatic logic [9:0] model_frame(input logic [7:0] d, input int par,
                                               input logic flip, input logic [1:0] stops,
                                               input int nstop);
        int   ones;
        logic good_bit;
        logic sent_bit;
        logic pe;
        logic fe;
        ones     = $countones(d);
        good_bit = (par == 1) ? ((ones % 2) == 0) : ((ones % 2) == 1);
        sent_bit = good_bit ^ flip;
        pe       = (par == 0) ? 1'b0 : (sent_bit != good_bit);
        fe       = (stops[0] == 1'b0) || (nstop == 2 && stops[1] == 1'b0);
        return {d, pe, fe};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic set_line(input int line, input logic v);
        case (line)
            0:       rx_a = v;
            1:       rx_b = v;
            default: rx_c = v;
        endcase
    endtask

    task automatic hold(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input int line, input logic [7:0] d, input int par,
                              input logic flip, input logic [1:0] stops, input int nstop);
        logic pbit;
        set_line(line, 1'b0);
        hold(16);
        for (int i = 0; i < 8; i++) begin
            set_line(line, d[i]);
            hold(16);
        end
        if (par != 0) begin
            pbit = (par == 1) ? ~^d : ^d;
            set_line(line, pbit ^ flip);
            hold(16);
        end
        for (int s = 0; s < nstop; s++) begin
            set_line(line, stops[s]);
            hold(16);
        end
        set_line(line, 1'b1);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst  = 1'b0;
        rx_a = 1'b1;
        rx_b = 1'b1;
        rx_c = 1'b1;
        hold(3);
        n_checks++;
        if ({data_a, dv_a, pe_a, fe_a, busy_a} !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_8n1: got %h expected 000", {data_a, dv_a, pe_a, fe_a, busy_a});
        end
        n_checks++;
        if ({data_b, dv_b, pe_b, fe_b, busy_b} !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_8o1: got %h expected 000", {data_b, dv_b, pe_b, fe_b, busy_b});
        end
        n_checks++;
        if ({data_c, dv_c, pe_c, fe_c, busy_c} !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_8n2: got %h expected 000", {data_c, dv_c, pe_c, fe_c, busy_c});
        end
        rst = 1'b1;
        hold(20);
        n_checks++;
        if ({busy_a, busy_b, busy_c} !== 3'b000 || obs_a.size() + obs_b.size() + obs_c.size() != 0) begin
            n_fail++;
            $display("FAIL idle_after_reset: busy=%b strobes=%0d expected busy=000 strobes=0",
                     {busy_a, busy_b, busy_c}, obs_a.size() + obs_b.size() + obs_c.size());
        end
    endtask

    task automatic test_basic_8n1();
        int c;
        obs_a.delete();
        t_a.delete();
        c = cyc;
        send_frame(0, 8'hA5, 0, 1'b0, 2'b11, 1);
        hold(40);
        n_checks++;
        if (obs_a.size() != 1) begin
            n_fail++;
            $display("FAIL basic_count: got %0d strobes expected 1", obs_a.size());
        end else begin
            n_checks++;
            if (obs_a[0] !== {8'hA5, 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL basic_data: got %h expected %h", obs_a[0], {8'hA5, 2'b00});
            end
            n_checks++;
            if (t_a[0] != c + 3 + 153) begin
                n_fail++;
                $display("FAIL basic_latency: strobe at cycle %0d expected %0d", t_a[0], c + 156);
            end
        end
        n_checks++;
        if (busy_rise_a != c + 3) begin
            n_fail++;
            $display("FAIL basic_busy_rise: at cycle %0d expected %0d", busy_rise_a, c + 3);
        end
        n_checks++;
        if (busy_a !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_busy_end: got %b expected 0", busy_a);
        end
    endtask

    task automatic test_parity();
        obs_b.delete();
        exp_q.delete();
        send_frame(1, 8'h07, 1, 1'b0, 2'b11, 1);
        exp_q.push_back(model_frame(8'h07, 1, 1'b0, 2'b11, 1));
        hold(20);
        send_frame(1, 8'h07, 1, 1'b1, 2'b11, 1);
        exp_q.push_back(model_frame(8'h07, 1, 1'b1, 2'b11, 1));
        hold(40);
        n_checks++;
        if (obs_b.size() != 2) begin
            n_fail++;
            $display("FAIL parity_count: got %0d strobes expected 2", obs_b.size());
        end else begin
            for (int i = 0; i < 2; i++) begin
                n_checks++;
                if (obs_b[i] !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL parity_frame%0d: got %h expected %h", i, obs_b[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_glitch();
        int c;
        obs_a.delete();
        c = cyc;
        set_line(0, 1'b0);
        hold(5);
        set_line(0, 1'b1);
        n_checks++;
        if (busy_a !== 1'b1 || busy_rise_a != c + 3) begin
            n_fail++;
            $display("FAIL glitch_busy_rise: busy=%b rise=%0d expected busy=1 rise=%0d",
                     busy_a, busy_rise_a, c + 3);
        end
        hold(6);
        n_checks++;
        if (busy_a !== 1'b0) begin
            n_fail++;
            $display("FAIL glitch_busy_fall: got %b expected 0 at cycle %0d", busy_a, cyc);
        end
        hold(200);
        n_checks++;
        if (obs_a.size() != 0) begin
            n_fail++;
            $display("FAIL glitch_no_strobe: got %0d strobes expected 0", obs_a.size());
        end
    endtask

    task automatic test_framing();
        obs_a.delete();
        send_frame(0, 8'h3C, 0, 1'b0, 2'b10, 1);
        set_line(0, 1'b0);
        hold(400);
        n_checks++;
        if (obs_a.size() != 1 || obs_a[0] !== {8'h3C, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL framing_error: strobes=%0d first=%h expected strobes=1 word=%h",
                     obs_a.size(), (obs_a.size() > 0) ? obs_a[0] : 10'h0, {8'h3C, 2'b01});
        end
        n_checks++;
        if (fe_a !== 1'b1) begin
            n_fail++;
            $display("FAIL framing_flag_persist: got %b expected 1", fe_a);
        end
        set_line(0, 1'b1);
        hold(50);
        n_checks++;
        if (obs_a.size() != 1) begin
            n_fail++;
            $display("FAIL framing_break_no_spurious: got %0d strobes expected 1", obs_a.size());
        end
        send_frame(0, 8'h81, 0, 1'b0, 2'b11, 1);
        hold(40);
        n_checks++;
        if (obs_a.size() != 2 || obs_a[obs_a.size()-1] !== {8'h81, 2'b00}) begin
            n_fail++;
            $display("FAIL framing_recover: strobes=%0d last=%h expected strobes=2 word=%h",
                     obs_a.size(), obs_a[obs_a.size()-1], {8'h81, 2'b00});
        end
    endtask

    task automatic test_reset_midframe();
        obs_a.delete();
        set_line(0, 1'b0);
        hold(16);
        for (int i = 0; i < 4; i++) begin
            set_line(0, 1'b1);
            hold(16);
        end
        set_line(0, 1'b1);
        hold(8);
        n_checks++;
        if (busy_a !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_busy_before: got %b expected 1", busy_a);
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if ({data_a, dv_a, pe_a, fe_a, busy_a} !== 12'h000) begin
            n_fail++;
            $display("FAIL midreset_outputs: got %h expected 000", {data_a, dv_a, pe_a, fe_a, busy_a});
        end
        hold(3);
        rst = 1'b1;
        hold(200);
        n_checks++;
        if (obs_a.size() != 0) begin
            n_fail++;
            $display("FAIL midreset_no_strobe: got %0d strobes expected 0", obs_a.size());
        end
        send_frame(0, 8'h12, 0, 1'b0, 2'b11, 1);
        hold(40);
        n_checks++;
        if (obs_a.size() != 1 || obs_a[0] !== {8'h12, 2'b00}) begin
            n_fail++;
            $display("FAIL midreset_recover: strobes=%0d word=%h expected strobes=1 word=%h",
                     obs_a.size(), (obs_a.size() > 0) ? obs_a[0] : 10'h0, {8'h12, 2'b00});
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] bytes [3];
        logic [7:0] d;
        bytes[0] = 8'h00;
        bytes[1] = 8'hFF;
        bytes[2] = 8'h55;
        obs_c.delete();
        exp_q.delete();
        for (int i = 0; i < 3; i++) begin
            send_frame(2, bytes[i], 0, 1'b0, 2'b11, 2);
            exp_q.push_back(model_frame(bytes[i], 0, 1'b0, 2'b11, 2));
        end
        for (int i = 0; i < 6; i++) begin
            d = 8'($urandom_range(0, 255));
            send_frame(2, d, 0, 1'b0, 2'b11, 2);
            exp_q.push_back(model_frame(d, 0, 1'b0, 2'b11, 2));
        end
        hold(40);
        n_checks++;
        if (obs_c.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d strobes expected %0d", obs_c.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                n_checks++;
                if (obs_c[i] !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL b2b_frame%0d: got %h expected %h", i, obs_c[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] d;
        logic       flip;
        logic       bad_stop;
        int         gap;
        // 8N1 with occasional framing errors
        obs_a.delete();
        exp_q.delete();
        for (int i = 0; i < 16; i++) begin
            d        = 8'($urandom_range(0, 255));
            bad_stop = ($urandom_range(0, 3) == 0);
            send_frame(0, d, 0, 1'b0, bad_stop ? 2'b10 : 2'b11, 1);
            exp_q.push_back(model_frame(d, 0, 1'b0, bad_stop ? 2'b10 : 2'b11, 1));
            gap = bad_stop ? $urandom_range(16, 40) : $urandom_range(0, 20);
            if (gap > 0) hold(gap);
        end
        hold(40);
        n_checks++;
        if (obs_a.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL rand_8n1_count: got %0d strobes expected %0d", obs_a.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                n_checks++;
                if (obs_a[i] !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL rand_8n1_frame%0d: got %h expected %h", i, obs_a[i], exp_q[i]);
                end
            end
        end
        // 8O1 with random parity corruption
        obs_b.delete();
        exp_q.delete();
        for (int i = 0; i < 16; i++) begin
            d    = 8'($urandom_range(0, 255));
            flip = 1'($urandom_range(0, 1));
            send_frame(1, d, 1, flip, 2'b11, 1);
            exp_q.push_back(model_frame(d, 1, flip, 2'b11, 1));
            gap = $urandom_range(0, 20);
            if (gap > 0) hold(gap);
        end
        hold(40);
        n_checks++;
        if (obs_b.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL rand_8o1_count: got %0d strobes expected %0d", obs_b.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                n_checks++;
                if (obs_b[i] !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL rand_8o1_frame%0d: got %h expected %h", i, obs_b[i], exp_q[i]);
                end
            end
        end
    endtask

    // ---------------- sequence / report ----------------
    initial begin
        test_reset();
        test_basic_8n1();
        test_parity();
        test_glitch();
        test_framing();
        test_reset_midframe();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
